// File: rtl/cfeb_kchar_framer_pkg.sv
// Shared CFEB trigger-link constants: K-character codes, separator layout and
// link state encodings. The receive-side sync monitor uses the same package.
package cfeb_kchar_framer_pkg;

    // 8b/10b K-characters carried in the upper byte of the separator word
    localparam logic [7:0] K_BC   = 8'hBC;
    localparam logic [7:0] K_FC   = 8'hFC;
    // Fixed data byte in the lower half of the separator word
    localparam logic [7:0] SEP_LO = 8'h50;

    // Three data words plus one separator per comparator frame
    localparam int unsigned WORDS_PER_FRAME = 4;

    // K flags per byte, [1] = upper byte
    localparam logic [1:0] ISK_DATA = 2'b00;
    localparam logic [1:0] ISK_SEP  = 2'b10;

    // Encoding is exported directly as link_state
    typedef enum logic [1:0] {
        LinkOff = 2'd0,
        LinkUp  = 2'd1,
        LinkRun = 2'd2
    } link_state_e;

    // Separator word: FC marker or plain BC comma, followed by the 50 byte
    function automatic logic [15:0] sep_word(input logic fc_marker);
        return {(fc_marker ? K_FC : K_BC), SEP_LO};
    endfunction

endpackage

// File: rtl/cfeb_kchar_framer.sv
// Transmit framer for the CFEB trigger fiber. Each 48-bit comparator frame is
// sent as three 16-bit data words and one K-character separator. The
// separator is BC50 except once every MARKER_PERIOD frames, when it is FC50.
// LINKUP sends zero-data frames so the far end can lock before RUN starts.
module cfeb_kchar_framer
    import cfeb_kchar_framer_pkg::*;
#(
    parameter int unsigned MARKER_PERIOD = 256,
    parameter int unsigned LINKUP_FRAMES = 64
) (
    input  logic        clock,
    input  logic        global_reset_n,
    input  logic        clk_lock,
    input  logic        fiber_enable,
    input  logic        ttc_resync,
    input  logic [47:0] data_in,
    output logic        frame_strobe,
    output logic [15:0] tx_data,
    output logic [1:0]  tx_isk,
    output logic        sync_done,
    output logic [7:0]  frame_cnt,
    output logic [1:0]  link_state
);

    localparam logic [1:0] LastPhase  = 2'(WORDS_PER_FRAME - 1);
    localparam logic [7:0] MarkerLast = 8'(MARKER_PERIOD - 1);
    localparam logic [7:0] LinkupLast = 8'(LINKUP_FRAMES - 1);

    link_state_e state_q;
    logic [1:0]  phase_q;
    logic [7:0]  cnt_q;
    logic [15:0] tx_data_q;
    logic [1:0]  tx_isk_q;
    logic        sync_done_q;
    logic        resync_pend_q;
    logic [47:0] hold_q;

    logic        link_ok;
    logic        last_phase;
    logic        fc_marker;
    logic        resync_now;
    logic [7:0]  cnt_run_next;
    logic [15:0] word_d;
    logic [1:0]  isk_d;

    // Frame timing decode and next-word mux
    always_comb begin
        link_ok      = clk_lock & fiber_enable;
        last_phase   = (phase_q == LastPhase);
        resync_now   = resync_pend_q | ttc_resync;
        fc_marker    = (state_q == LinkRun) && (cnt_q == MarkerLast);
        cnt_run_next = (cnt_q == MarkerLast) ? 8'd0 : cnt_q + 8'd1;

        // Strobe one cycle ahead of word0 so the hold register feeds the next frame
        frame_strobe = last_phase &&
                       ((state_q == LinkRun) ||
                        ((state_q == LinkUp) && (cnt_q == LinkupLast)));

        word_d = 16'h0000;
        isk_d  = ISK_DATA;
        if (state_q == LinkRun) begin
            unique case (phase_q)
                2'd0: word_d = hold_q[15:0];
                2'd1: word_d = hold_q[31:16];
                2'd2: word_d = hold_q[47:32];
                2'd3: begin
                    word_d = sep_word(fc_marker);
                    isk_d  = ISK_SEP;
                end
            endcase
        end else if ((state_q == LinkUp) && last_phase) begin
            // Linkup frames carry zero data and never the FC marker
            word_d = sep_word(1'b0);
            isk_d  = ISK_SEP;
        end
    end

    // Link FSM, phase and frame counters, resync handling and registered outputs
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q       <= LinkOff;
            phase_q       <= 2'd0;
            cnt_q         <= 8'd0;
            tx_data_q     <= 16'h0000;
            tx_isk_q      <= ISK_DATA;
            sync_done_q   <= 1'b0;
            resync_pend_q <= 1'b0;
        end else if (!link_ok) begin
            // Losing lock or enable abandons the frame in flight
            state_q       <= LinkOff;
            phase_q       <= 2'd0;
            cnt_q         <= 8'd0;
            tx_data_q     <= 16'h0000;
            tx_isk_q      <= ISK_DATA;
            sync_done_q   <= 1'b0;
            resync_pend_q <= 1'b0;
        end else begin
            tx_data_q <= word_d;
            tx_isk_q  <= isk_d;
            case (state_q)
                LinkOff: begin
                    state_q       <= LinkUp;
                    phase_q       <= 2'd0;
                    cnt_q         <= 8'd0;
                    sync_done_q   <= 1'b0;
                    resync_pend_q <= 1'b0;
                end

                LinkUp: begin
                    phase_q <= phase_q + 2'd1;
                    if (last_phase) begin
                        if (cnt_q == LinkupLast) begin
                            // Count reaches zero on RUN entry, which also satisfies a pending resync
                            state_q       <= LinkRun;
                            cnt_q         <= 8'd0;
                            sync_done_q   <= 1'b1;
                            resync_pend_q <= 1'b0;
                        end else if (resync_now) begin
                            cnt_q         <= 8'd0;
                            resync_pend_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end else if (ttc_resync) begin
                        resync_pend_q <= 1'b1;
                    end
                end

                LinkRun: begin
                    phase_q <= phase_q + 2'd1;
                    if (last_phase) begin
                        // Realign only at a frame boundary so the frame in flight completes intact
                        if (resync_now) begin
                            cnt_q         <= 8'd0;
                            resync_pend_q <= 1'b0;
                            sync_done_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_run_next;
                        end
                    end else if (ttc_resync) begin
                        resync_pend_q <= 1'b1;
                        sync_done_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q       <= LinkOff;
                    phase_q       <= 2'd0;
                    cnt_q         <= 8'd0;
                    sync_done_q   <= 1'b0;
                    resync_pend_q <= 1'b0;
                end
            endcase
        end
    end

    // Frame hold register, captured one cycle before word0 goes out
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            hold_q <= 48'h0;
        end else if (frame_strobe) begin
            hold_q <= data_in;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_isk     = tx_isk_q;
    assign sync_done  = sync_done_q;
    assign frame_cnt  = cnt_q;
    assign link_state = state_q;

endmodule
